hlp_decim: RTL and testbench

HLP_DECIM -- requirements
Module: hlp_decim

---
 rtl/hlp_decim.sv | 91 +++++++++
 tb/tb_hlp_decim.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hlp_decim.sv
// Keep-1-in-DECIM decimator feeding a 4-entry output FIFO with a valid/ready consumer port.
// Optional: define HLP_DECIM_OVF_CNT_EN to add the saturating ovf_count drop counter port.
module hlp_decim #(
  parameter int DECIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [15:0] filter_in,
  output logic [15:0] decim_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  fifo_level
`ifdef HLP_DECIM_OVF_CNT_EN
  ,
  output logic [7:0]  ovf_count
`endif
);

  localparam logic [4:0] PHASE_LAST = 5'(DECIM - 1);

  logic [4:0]  phase_reg;
  logic [1:0]  wr_ptr_reg;
  logic [1:0]  rd_ptr_reg;
  logic [2:0]  level_reg;
  logic [15:0] mem [4];

  logic kept;
  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    kept = clk_enable && (phase_reg == 5'd0);
    full = (level_reg == 3'd4);
    pop  = (level_reg != 3'd0) && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    push = kept && (!full || pop);
    drop = kept && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= 5'd0;
    end else if (clk_enable) begin
      phase_reg <= (phase_reg == PHASE_LAST) ? 5'd0 : phase_reg + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= 2'd0;
      rd_ptr_reg <= 2'd0;
      level_reg  <= 3'd0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      level_reg <= level_reg + {2'b00, push} - {2'b00, pop};
    end
  end

  // Storage needs no reset: the output is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr_reg] <= filter_in;
  end

  always_comb begin
    out_valid  = (level_reg != 3'd0);
    fifo_level = level_reg;
    decim_out  = out_valid ? mem[rd_ptr_reg] : 16'h0000;
  end

`ifdef HLP_DECIM_OVF_CNT_EN
  logic [7:0] ovf_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_reg <= 8'd0;
    end else if (drop && (ovf_reg != 8'hFF)) begin
      ovf_reg <= ovf_reg + 8'd1;
    end
  end

  assign ovf_count = ovf_reg;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_hlp_decim.sv
// Bench for hlp_decim: DECIM=4 and DECIM=1 instances share stimulus; a queue model checks every cycle.
module tb_hlp_decim;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b0;
  logic [15:0] filter_in = 16'h0;
  logic        out_ready = 1'b0;

  logic [15:0] out4, out1;
  logic        valid4, valid1;
  logic [2:0]  level4, level1;
`ifdef HLP_DECIM_OVF_CNT_EN
  logic [7:0]  ovf4, ovf1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hlp_decim #(.DECIM(4)) u4 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
    .decim_out(out4), .out_valid(valid4), .out_ready(out_ready), .fifo_level(level4)
`ifdef HLP_DECIM_OVF_CNT_EN
    , .ovf_count(ovf4)
`endif
  );

  hlp_decim #(.DECIM(1)) u1 (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
    .decim_out(out1), .out_valid(valid1), .out_ready(out_ready), .fifo_level(level1)
`ifdef HLP_DECIM_OVF_CNT_EN
    , .ovf_count(ovf1)
`endif
  );

  // Model state: kept samples, enabled-sample count since reset, dropped-sample count.
  logic [15:0] q4[$], q1[$];
  int en4 = 0, en1 = 0, drop4 = 0, drop1 = 0;
  logic [15:0] got4[$], got1[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_seq(input string nm, input logic [15:0] got[$], input logic [15:0] exp[$]);
    chk({nm, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s[%0d]", nm, i), int'(got[i]), int'(exp[i]));
  endtask

  // Model update on each rising edge from the inputs held across it.
  initial begin
    bit p, k;
    forever begin
      @(posedge clk);
      if (reset) begin
        q4.delete(); q1.delete();
        en4 = 0; en1 = 0; drop4 = 0; drop1 = 0;
      end else begin
        p = (q4.size() != 0) && out_ready;
        k = clk_enable && (en4 % 4 == 0);
        if (clk_enable) en4++;
        if (p) void'(q4.pop_front());
        if (k) begin
          if (q4.size() < 4) q4.push_back(filter_in);
          else if (drop4 < 255) drop4++;
        end
        p = (q1.size() != 0) && out_ready;
        k = clk_enable;
        if (p) void'(q1.pop_front());
        if (k) begin
          if (q1.size() < 4) q1.push_back(filter_in);
          else if (drop1 < 255) drop1++;
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge; log accepted samples.
  initial begin
    forever begin
      @(negedge clk);
      chk("u4 out_valid", int'(valid4), int'(q4.size() != 0));
      chk("u4 fifo_level", int'(level4), q4.size());
      chk("u4 decim_out", int'(out4), (q4.size() != 0) ? int'(q4[0]) : 0);
      chk("u1 out_valid", int'(valid1), int'(q1.size() != 0));
      chk("u1 fifo_level", int'(level1), q1.size());
      chk("u1 decim_out", int'(out1), (q1.size() != 0) ? int'(q1[0]) : 0);
`ifdef HLP_DECIM_OVF_CNT_EN
      chk("u4 ovf_count", int'(ovf4), drop4);
      chk("u1 ovf_count", int'(ovf1), drop1);
`endif
      if (valid4 && out_ready) got4.push_back(out4);
      if (valid1 && out_ready) got1.push_back(out1);
    end
  end

  task automatic cyc(input logic e, input logic [15:0] d, input logic r);
    clk_enable = e; filter_in = d; out_ready = r;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 16'h7777, 1'b0);
    cyc(1'b1, 16'h7777, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] exp[$];

    do_reset();
    chk("reset out_valid", int'(valid4), 0);
    chk("reset fifo_level", int'(level4), 0);
    chk("reset decim_out", int'(out4), 0);
`ifdef HLP_DECIM_OVF_CNT_EN
    chk("reset ovf_count", int'(ovf4), 0);
`endif

    // Continuous enable ramp at DECIM=4.
    got4.delete();
    cyc(1'b1, 16'd0, 1'b1);
    chk("ramp latency valid", int'(valid4), 1);
    chk("ramp latency data", int'(out4), 0);
    for (int i = 1; i < 16; i++) cyc(1'b1, 16'(i), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1);
    exp = '{16'h0000, 16'h0004, 16'h0008, 16'h000c};
    chk_seq("ramp seq", got4, exp);

    // Enable toggling every cycle.
    do_reset();
    got4.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 16'(i), 1'b1);
      cyc(1'b0, 16'hDEAD, 1'b1);
    end
    cyc(1'b0, 16'h0, 1'b1);
    exp = '{16'h0000, 16'h0004, 16'h0008, 16'h000c};
    chk_seq("toggle seq", got4, exp);

    // Overflow at DECIM=1 with a stalled consumer.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'hA000 + 16'(i), 1'b0);
    chk("ovf level", int'(level1), 4);
`ifdef HLP_DECIM_OVF_CNT_EN
    chk("ovf count", int'(ovf1), 2);
`endif
    got1.delete();
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0, 1'b1);
    exp = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    chk_seq("ovf drain", got1, exp);

    // Push and pop together while full.
    do_reset();
    got1.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'hB000 + 16'(i), 1'b0);
    cyc(1'b1, 16'hB004, 1'b1);
    chk("full pushpop level", int'(level1), 4);
`ifdef HLP_DECIM_OVF_CNT_EN
    chk("full pushpop ovf", int'(ovf1), 0);
`endif
    for (int i = 0; i < 6; i++) cyc(1'b0, 16'h0, 1'b1);
    exp = '{16'hB000, 16'hB001, 16'hB002, 16'hB003, 16'hB004};
    chk_seq("full pushpop seq", got1, exp);

    // Mid-operation reset with level 3 and phase 2.
    do_reset();
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0);
    chk("pre-reset level", int'(level4), 3);
    reset = 1'b1;
    cyc(1'b1, 16'h5555, 1'b0);
    reset = 1'b0;
    chk("mid reset valid", int'(valid4), 0);
    chk("mid reset level", int'(level4), 0);
    chk("mid reset data", int'(out4), 0);
    got4.delete();
    cyc(1'b1, 16'hC123, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    exp = '{16'hC123};
    chk_seq("post reset seq", got4, exp);

    // Negative full-scale samples pass bit-exact.
    do_reset();
    got1.delete();
    cyc(1'b1, 16'h8000, 1'b1);
    cyc(1'b1, 16'hFFFF, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    cyc(1'b0, 16'h0, 1'b1);
    exp = '{16'h8000, 16'hFFFF};
    chk_seq("negative seq", got1, exp);

`ifdef HLP_DECIM_OVF_CNT_EN
    do_reset();
    for (int i = 0; i < 262; i++) cyc(1'b1, 16'(i), 1'b0);
    chk("ovf saturate", int'(ovf1), 255);
`endif

    cyc(1'b0, 16'h0, 1'b0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
